seq_detect_multi: RTL and testbench

Parametrised Moore-style serial pattern detector and the successor to the fixed-pattern detector FSMs.
- Compares a 1-bit serial stream against NUM_PAT run-time-programmable patterns of PAT_LEN bits each.
- Reports per-pattern match pulses, a priority-encoded match id and a saturating match count.
- Sits after the serial front end; consumed by the control/status logic.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/seq_det_cmp.sv | 54 +++++
 rtl/seq_detect_multi.sv | 132 +++++++++++++
 tb/tb_seq_detect_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the multi-pattern serial detector.
//   state_t      : detector FSM state (FILL while history warms up, RUN once full)
//   MAX_PAT_LEN  : largest supported pattern length
//   MAX_NUM_PAT  : largest supported number of pattern slots
//   FC_W         : width of the history fill counter (holds 0..MAX_PAT_LEN)
//   prio_enc()   : lowest-set-bit index of a slot vector, 0 when empty
package seq_det_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_PAT_LEN = 16;
    localparam int MAX_NUM_PAT = 8;
    localparam int FC_W        = 5;

    // Scans from the top down so the lowest set index is the one that sticks.
    function automatic logic [2:0] prio_enc(input logic [MAX_NUM_PAT-1:0] v);
        logic [2:0] id;
        id = '0;
        for (int i = MAX_NUM_PAT - 1; i >= 0; i--) begin
            if (v[i]) id = 3'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// seq_det_cmp: one pattern slot -- the programmable pattern register and its
// comparator against the candidate (next) history value.
// Optional build macro SEQ_DETECT_MASK_EN adds a per-slot don't-care mask.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (pattern/mask -> 0)
//   wr        : write this slot with wdata (and wmask when masking is built in)
//   wdata     : new pattern, bit PAT_LEN-1 is the oldest bit
//   wmask     : (SEQ_DETECT_MASK_EN only) 1 = bit position ignored in compare
//   en        : slot enable, a disabled slot never reports a hit
//   hist_nxt  : history value including the bit being accepted this cycle
//   hit       : combinational compare result
module seq_det_cmp
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [PAT_LEN-1:0] wdata,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_LEN-1:0] wmask,
`endif
    input  logic               en,
    input  logic [PAT_LEN-1:0] hist_nxt,
    output logic               hit
);

    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] care;

    always_ff @(posedge clk) begin
        if (rst)     pat <= '0;
        else if (wr) pat <= wdata;
    end

`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_LEN-1:0] mask;

    always_ff @(posedge clk) begin
        if (rst)     mask <= '0;
        else if (wr) mask <= wmask;
    end

    assign care = ~mask;
`else
    assign care = '1;
`endif

    // The register still holds the old pattern during a write cycle, so a bit
    // accepted alongside pat_wr is compared against the previous contents.
    assign hit = en && (((hist_nxt ^ pat) & care) == '0);

endmodule

// File: rtl/seq_detect_multi.sv
// seq_detect_multi: Moore-style serial detector comparing a 1-bit stream
// against NUM_PAT run-time programmable patterns of PAT_LEN bits.
// Optional build macro SEQ_DETECT_MASK_EN adds the pat_mask input.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears slots too)
//   in_valid   : xe is accepted this cycle; otherwise all state is frozen
//   xe         : serial data bit
//   overlap    : 1 = keep history after a match, 0 = restart filling
//   pat_wr     : write slot pat_sel with pat_data (sel >= NUM_PAT ignored)
//   pat_sel    : slot index to write
//   pat_data   : pattern, bit PAT_LEN-1 is the first-received bit
//   pat_mask   : (SEQ_DETECT_MASK_EN only) don't-care bits for the write
//   pat_en     : per-slot enable, applies to the bit accepted the same cycle
//   match      : per-slot one-cycle match pulse (registered)
//   match_any  : OR of match
//   match_id   : lowest matching slot index, 0 when none
//   match_cnt  : saturating count of match_any cycles
//   cnt_clr    : clear match_cnt, wins over a same-cycle increment
module seq_detect_multi
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int NUM_PAT = 4,
    parameter int ID_W    = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               xe,
    input  logic               overlap,
    input  logic               pat_wr,
    input  logic [ID_W-1:0]    pat_sel,
    input  logic [PAT_LEN-1:0] pat_data,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_LEN-1:0] pat_mask,
`endif
    input  logic [NUM_PAT-1:0] pat_en,
    output logic [NUM_PAT-1:0] match,
    output logic               match_any,
    output logic [ID_W-1:0]    match_id,
    output logic [CNT_W-1:0]   match_cnt,
    input  logic               cnt_clr
);

    state_t             state, state_nxt;
    logic [PAT_LEN-1:0] hist, hist_shift, hist_nxt;
    logic [FC_W-1:0]    fill_cnt, fill_nxt;
    logic [NUM_PAT-1:0] hit, hit_vld;
    logic               cmp_en;
    logic               any_hit;

    assign hist_shift = {hist[PAT_LEN-2:0], xe};

    // The bit that completes the first full window is compared too, so the
    // compare opens one bit before the FSM actually reaches RUN.
    assign cmp_en  = in_valid && ((state == RUN) || (fill_cnt == FC_W'(PAT_LEN - 1)));
    assign hit_vld = cmp_en ? hit : '0;
    assign any_hit = |hit_vld;

    for (genvar i = 0; i < NUM_PAT; i++) begin : gen_slot
        seq_det_cmp #(
            .PAT_LEN (PAT_LEN)
        ) u_cmp (
            .clk      (clk),
            .rst      (rst),
            .wr       (pat_wr && (pat_sel == ID_W'(i))),
            .wdata    (pat_data),
`ifdef SEQ_DETECT_MASK_EN
            .wmask    (pat_mask),
`endif
            .en       (pat_en[i]),
            .hist_nxt (hist_shift),
            .hit      (hit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            hist     <= '0;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hist     <= hist_nxt;
            fill_cnt <= fill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill_cnt;
        if (in_valid) begin
            hist_nxt = hist_shift;
            case (state)
                FILL: begin
                    fill_nxt = fill_cnt + FC_W'(1);
                    if (fill_cnt == FC_W'(PAT_LEN - 1)) state_nxt = RUN;
                end
                RUN:     ;
                default: state_nxt = FILL;
            endcase
            // Non-overlapping mode: a match consumes the whole window.
            if (any_hit && !overlap) begin
                hist_nxt  = '0;
                fill_nxt  = '0;
                state_nxt = FILL;
            end
        end
    end

    // Match outputs are registered; with in_valid low hit_vld is 0, so the
    // pulse lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            match     <= '0;
            match_any <= 1'b0;
            match_id  <= '0;
        end else begin
            match     <= hit_vld;
            match_any <= any_hit;
            match_id  <= ID_W'(prio_enc(MAX_NUM_PAT'(hit_vld)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)                     match_cnt <= '0;
        else if (any_hit && (match_cnt != '1))  match_cnt <= match_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_seq_detect_multi.sv
// tb_seq_detect_multi: scoreboard bench for seq_detect_multi (PAT_LEN=4,
// NUM_PAT=4, CNT_W=2). Each driven cycle pushes the hand-computed output
// expected after that clock edge; a monitor pops and compares every cycle.
module tb_seq_detect_multi;

    localparam int PL = 4;
    localparam int NP = 4;
    localparam int IW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          xe = 1'b0;
    logic          overlap = 1'b0;
    logic          pat_wr = 1'b0;
    logic [IW-1:0] pat_sel = '0;
    logic [PL-1:0] pat_data = '0;
    logic [NP-1:0] pat_en = '0;
    logic          cnt_clr = 1'b0;
    logic [NP-1:0] match;
    logic          match_any;
    logic [IW-1:0] match_id;
    logic [CW-1:0] match_cnt;

    // Staged controls, applied at the next driven edge.
    logic [NP-1:0] en_s = '0;
    logic          ov_s = 1'b0;

    typedef struct packed {
        logic [NP-1:0] m;
        logic [CW-1:0] c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    seq_detect_multi #(
        .PAT_LEN (PL),
        .NUM_PAT (NP),
        .ID_W    (IW),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .xe        (xe),
        .overlap   (overlap),
        .pat_wr    (pat_wr),
        .pat_sel   (pat_sel),
        .pat_data  (pat_data),
        .pat_en    (pat_en),
        .match     (match),
        .match_any (match_any),
        .match_id  (match_id),
        .match_cnt (match_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, ex, $time);
        end
    endtask

    // One driven cycle plus its expected post-edge output.
    task automatic cyc(input logic v, input logic x, input logic wr,
                       input logic [IW-1:0] sel, input logic [PL-1:0] data,
                       input logic clr, input logic r,
                       input logic [NP-1:0] em, input logic [CW-1:0] ec);
        @(negedge clk);
        in_valid = v;
        xe       = x;
        pat_wr   = wr;
        pat_sel  = sel;
        pat_data = data;
        cnt_clr  = clr;
        rst      = r;
        pat_en   = en_s;
        overlap  = ov_s;
        q.push_back('{m: em, c: ec});
    endtask

    task automatic bit_(input logic x, input logic [NP-1:0] em, input logic [CW-1:0] ec);
        cyc(1'b1, x, 1'b0, '0, '0, 1'b0, 1'b0, em, ec);
    endtask

    task automatic idle(input logic [CW-1:0] ec);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, ec);
    endtask

    task automatic reset_();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic wrp(input logic [IW-1:0] sel, input logic [PL-1:0] data, input logic [CW-1:0] ec);
        cyc(1'b0, 1'b0, 1'b1, sel, data, 1'b0, 1'b0, '0, ec);
    endtask

    // Monitor: outputs are registered, so every edge presents a result.
    initial begin
        exp_t          e;
        logic [IW-1:0] eid;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e   = q.pop_front();
                eid = '0;
                for (int i = NP - 1; i >= 0; i--)
                    if (e.m[i]) eid = IW'(i);
                chk("match",     32'(match),     32'(e.m));
                chk("match_any", 32'(match_any), 32'(|e.m));
                chk("match_id",  32'(match_id),  32'(eid));
                chk("match_cnt", 32'(match_cnt), 32'(e.c));
            end
        end
    end

    initial begin
        // Reset state
        reset_();

        // Overlapping: 1011011 -> pulses after bits 4 and 7
        en_s = 4'b0001; ov_s = 1'b1;
        wrp(3'd0, 4'b1011, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b0, 4'b0000, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b1, 4'b0001, 2'd1);
        bit_(1'b0, 4'b0000, 2'd1); bit_(1'b1, 4'b0000, 2'd1);
        bit_(1'b1, 4'b0001, 2'd2); idle(2'd2);

        // Non-overlapping: single pulse after bit 4
        reset_();
        ov_s = 1'b0;
        wrp(3'd0, 4'b1011, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b0, 4'b0000, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b1, 4'b0001, 2'd1);
        bit_(1'b0, 4'b0000, 2'd1); bit_(1'b1, 4'b0000, 2'd1);
        bit_(1'b1, 4'b0000, 2'd1);

        // Two identical slots, priority, same-cycle enable, ignored slot
        // select, same-cycle pattern write
        reset_();
        ov_s = 1'b1; en_s = 4'b0011;
        wrp(3'd0, 4'b1111, 2'd0);
        wrp(3'd1, 4'b1111, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b1, 4'b0000, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b1, 4'b0011, 2'd1);
        en_s = 4'b0010;
        bit_(1'b1, 4'b0010, 2'd2);
        en_s = 4'b0011;
        wrp(3'd5, 4'b0000, 2'd2);
        bit_(1'b1, 4'b0011, 2'd3);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 4'b0011, 2'd3);
        bit_(1'b1, 4'b0010, 2'd3);

        // Gap in in_valid: history frozen, no output during the gap
        reset_();
        en_s = 4'b0001;
        wrp(3'd0, 4'b1011, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b0, 4'b0000, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0);
        for (int i = 0; i < 5; i++) idle(2'd0);
        bit_(1'b1, 4'b0001, 2'd1);

        // Counter saturation at 3, then cnt_clr beating a concurrent match
        reset_();
        wrp(3'd0, 4'b0000, 2'd0);
        bit_(1'b0, 4'b0000, 2'd0); bit_(1'b0, 4'b0000, 2'd0);
        bit_(1'b0, 4'b0000, 2'd0); bit_(1'b0, 4'b0001, 2'd1);
        bit_(1'b0, 4'b0001, 2'd2); bit_(1'b0, 4'b0001, 2'd3);
        bit_(1'b0, 4'b0001, 2'd3); bit_(1'b0, 4'b0001, 2'd3);
        bit_(1'b0, 4'b0001, 2'd3);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'b0001, 2'd0);
        bit_(1'b0, 4'b0001, 2'd1);

        // Reset mid-fill: refill from scratch, slots all read 0 afterwards
        reset_();
        en_s = 4'b0001;
        wrp(3'd0, 4'b1011, 2'd0);
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b0, 4'b0000, 2'd0);
        reset_();
        en_s = 4'b1111;
        bit_(1'b1, 4'b0000, 2'd0); bit_(1'b1, 4'b0000, 2'd0);
        bit_(1'b0, 4'b0000, 2'd0); bit_(1'b0, 4'b0000, 2'd0);
        bit_(1'b0, 4'b0000, 2'd0); bit_(1'b0, 4'b1111, 2'd1);
        idle(2'd1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
